// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Works on operand magnitudes and fixes signs in a final cycle; divide-by-zero and overflow finish on accept.

module divider_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] full;
  assign full        = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
  assign {cout, sum} = full;
endmodule

module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  // op[0] selects unsigned, op[1] selects remainder
  logic             sgn_in, neg_a_in, neg_b_in, ovf_in;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  assign sgn_in   = ~op[0];
  assign neg_a_in = sgn_in & dividend[WIDTH-1];
  assign neg_b_in = sgn_in & divisor[WIDTH-1];
  assign mag_a_in = neg_a_in ? -dividend : dividend;
  assign mag_b_in = neg_b_in ? -divisor  : divisor;
  assign ovf_in   = sgn_in && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  logic [WIDTH-1:0] rem_sh, diff;
  logic             cout, qbit;

  assign rem_sh = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};

  divider_add #(.W(WIDTH)) u_sub (
    .a    (rem_sh),
    .b    (dvs_q),
    .sub  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // The bit shifted out of rem_q is the 33rd bit of the trial value; if set the
  // trial value exceeds any divisor, and the low WIDTH bits of diff are exact.
  assign qbit = rem_q[WIDTH-1] | cout;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          neg_a_d = neg_a_in;
          neg_b_d = neg_b_in;
          quot_d  = mag_a_in;
          dvs_d   = mag_b_in;
          rem_d   = '0;
          cnt_d   = '0;
          if (divisor == '0) begin
            result_d = op[1] ? dividend : '1;
            state_d  = DONE;
          end else if (ovf_in) begin
            result_d = op[1] ? '0 : dividend;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = qbit ? diff : rem_sh;
        quot_d = {quot_q[WIDTH-2:0], qbit};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) result_d = neg_a_q ? -rem_q : rem_q;
        else         result_d = (neg_a_q ^ neg_b_q) ? -quot_q : quot_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
endmodule
